// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter.
// Holds the ALU control codes, the result flag codes and the FSM state encoding.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_SUM = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_MAX = 3'b101;
  localparam logic [2:0] OP_MIN = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  localparam logic [3:0] FLAG_A = 4'hA;
  localparam logic [3:0] FLAG_B = 4'hB;
  localparam logic [3:0] FLAG_E = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [1:0] req0_a;
  logic [1:0] req0_b;

  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [1:0] req1_a;
  logic [1:0] req1_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_data;

  logic [1:0] alu_a;
  logic [1:0] alu_b;
  logic [2:0] alu_ctrl;
  logic [3:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result
  );

endinterface

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone valid requester wins outright,
// and when both are valid rr_ptr picks the winner. Grant is one-hot or zero.
module rr_arbiter2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       rr_ptr,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
    else                grant = valid;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: arbitrate, issue, wait out
// the ALU latency, capture the result and return it tagged with the requester id.
//
// state      | meaning
// IDLE       | arbitrating; ready asserted combinationally for the winner
// ISSUE      | ALU inputs driven, counting down ALU_LATENCY cycles
// CAPTURE    | ALU result valid; latched into rsp_data at end of cycle
// RESP       | response held until rsp_ready
module alu_arbiter #(
  parameter int ALU_LATENCY = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  import alu_arbiter_pkg::*;

  localparam int LAT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALU_LATENCY - 1);

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic             cur_id;
  logic [1:0]       valid;
  logic [1:0]       grant;
  logic [LAT_W-1:0] lat_cnt;
  logic             accept;
  logic             rsp_done;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_arb (
    .valid  (valid),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Reset gates acceptance so ready stays low while reset is held.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!reset && (grant != 2'b00)) begin
          accept    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (lat_cnt == '0) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.req0_ready = accept & grant[0];
  assign bus.req1_ready = accept & grant[1];
  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_id     = cur_id;
  assign busy           = (state != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr       <= 1'b0;
      cur_id       <= 1'b0;
      bus.alu_a    <= 2'b00;
      bus.alu_b    <= 2'b00;
      bus.alu_ctrl <= 3'b000;
      bus.rsp_data <= 4'h0;
      lat_cnt      <= '0;
    end else begin
      if (accept) begin
        bus.alu_a    <= grant[1] ? bus.req1_a  : bus.req0_a;
        bus.alu_b    <= grant[1] ? bus.req1_b  : bus.req0_b;
        bus.alu_ctrl <= grant[1] ? bus.req1_op : bus.req0_op;
        cur_id       <= grant[1];
        rr_ptr       <= ~grant[1];
        lat_cnt      <= LAT_LOAD;
      end
      if ((state == ST_ISSUE) && (lat_cnt != '0)) lat_cnt <= lat_cnt - LAT_W'(1);
      if (state == ST_CAPTURE) bus.rsp_data <= bus.alu_result;
    end
  end

  // Completion counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (rsp_done) begin
      if (!cur_id && (cnt0 != '1)) cnt0 <= cnt0 + CNT_W'(1);
      if (cur_id && (cnt1 != '1))  cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench: a default instance for arbitration/backpressure, and an
// instance with ALU_LATENCY=3, CNT_W=2 for reset, latency and saturation.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clock;
  logic       rst0, rst1;
  logic       busy0, busy1;
  logic [7:0] cnt0_0, cnt1_0;
  logic [1:0] cnt0_1, cnt1_1;
  logic [3:0] res0;
  logic [3:0] pipe1 [3];
  int         checks;
  int         errors;

  alu_arbiter_if bus0 ();
  alu_arbiter_if bus1 ();

  alu_arbiter u_dut0 (
    .clock (clock), .reset (rst0), .bus (bus0),
    .busy (busy0), .cnt0 (cnt0_0), .cnt1 (cnt1_0)
  );

  alu_arbiter #(.ALU_LATENCY(3), .CNT_W(2)) u_dut1 (
    .clock (clock), .reset (rst1), .bus (bus1),
    .busy (busy1), .cnt0 (cnt0_1), .cnt1 (cnt1_1)
  );

  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
    logic [3:0] xa, xb;
    xa = {2'b00, a};
    xb = {2'b00, b};
    case (op)
      OP_AND:  return xa & xb;
      OP_OR:   return xa | xb;
      OP_SUM:  return xa + xb;
      OP_SUB:  return xa - xb;
      OP_MUL:  return xa * xb;
      OP_MAX:  return (a > b) ? FLAG_A : ((a < b) ? FLAG_B : FLAG_E);
      OP_MIN:  return (a < b) ? FLAG_A : ((a > b) ? FLAG_B : FLAG_E);
      default: return (a == b) ? FLAG_E : 4'h0;
    endcase
  endfunction

  // Bench-side registered ALUs: one stage for dut0, three stages for dut1.
  always @(posedge clock) begin
    res0     <= alu_f(bus0.alu_ctrl, bus0.alu_a, bus0.alu_b);
    pipe1[0] <= alu_f(bus1.alu_ctrl, bus1.alu_a, bus1.alu_b);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign bus0.alu_result = res0;
  assign bus1.alu_result = pipe1[2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One req0 operation on dut1 from acceptance to counted completion.
  task automatic op1(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                     input logic [3:0] exp_data, input logic [1:0] exp_cnt);
    bus1.req0_op    = op;
    bus1.req0_a     = a;
    bus1.req0_b     = b;
    bus1.req0_valid = 1'b1;
    #1;
    chk("l3_ready", {7'd0, bus1.req0_ready}, 8'd1);
    tick();
    bus1.req0_valid = 1'b0;
    for (int c = 1; c < 5; c++) begin
      chk("l3_wait", {7'd0, bus1.rsp_valid}, 8'd0);
      tick();
    end
    chk("l3_rsp_valid", {7'd0, bus1.rsp_valid}, 8'd1);
    chk("l3_rsp_data", {4'd0, bus1.rsp_data}, {4'd0, exp_data});
    chk("l3_rsp_id", {7'd0, bus1.rsp_id}, 8'd0);
    tick();
    chk("l3_done", {7'd0, bus1.rsp_valid}, 8'd0);
    chk("sat_cnt0", {6'd0, cnt0_1}, {6'd0, exp_cnt});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    bus0.req0_valid = 1'b1; bus0.req0_op = OP_MUL; bus0.req0_a = 2'd3; bus0.req0_b = 2'd3;
    bus0.req1_valid = 1'b1; bus0.req1_op = OP_SUB; bus0.req1_a = 2'd1; bus0.req1_b = 2'd2;
    bus0.rsp_ready  = 1'b1;
    bus1.req0_valid = 1'b0; bus1.req0_op = OP_AND; bus1.req0_a = 2'd0; bus1.req0_b = 2'd0;
    bus1.req1_valid = 1'b0; bus1.req1_op = OP_AND; bus1.req1_a = 2'd0; bus1.req1_b = 2'd0;
    bus1.rsp_ready  = 1'b1;
    tick();
    tick();

    chk("rst_rsp_valid", {7'd0, bus0.rsp_valid}, 8'd0);
    chk("rst_rsp_id", {7'd0, bus0.rsp_id}, 8'd0);
    chk("rst_rsp_data", {4'd0, bus0.rsp_data}, 8'd0);
    chk("rst_alu_a", {6'd0, bus0.alu_a}, 8'd0);
    chk("rst_alu_b", {6'd0, bus0.alu_b}, 8'd0);
    chk("rst_alu_ctrl", {5'd0, bus0.alu_ctrl}, 8'd0);
    chk("rst_busy", {7'd0, busy0}, 8'd0);
    chk("rst_cnt0", cnt0_0, 8'd0);
    chk("rst_cnt1", cnt1_0, 8'd0);
    chk("rst_ready0", {7'd0, bus0.req0_ready}, 8'd0);
    chk("rst_ready1", {7'd0, bus0.req1_ready}, 8'd0);

    // Contention: both valid out of reset, rr_ptr=0 favours requester 0.
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("cont_ready0", {7'd0, bus0.req0_ready}, 8'd1);
    chk("cont_ready1", {7'd0, bus0.req1_ready}, 8'd0);
    tick();
    chk("cont_busy", {7'd0, busy0}, 8'd1);
    chk("cont_alu_a", {6'd0, bus0.alu_a}, 8'd3);
    chk("cont_alu_b", {6'd0, bus0.alu_b}, 8'd3);
    chk("cont_alu_ctrl", {5'd0, bus0.alu_ctrl}, {5'd0, OP_MUL});
    chk("cont_issue_ready0", {7'd0, bus0.req0_ready}, 8'd0);
    chk("cont_issue_ready1", {7'd0, bus0.req1_ready}, 8'd0);
    chk("cont_c1_valid", {7'd0, bus0.rsp_valid}, 8'd0);
    tick();
    chk("cont_c2_valid", {7'd0, bus0.rsp_valid}, 8'd0);
    tick();
    chk("cont_r1_valid", {7'd0, bus0.rsp_valid}, 8'd1);
    chk("cont_r1_id", {7'd0, bus0.rsp_id}, 8'd0);
    chk("cont_r1_data", {4'd0, bus0.rsp_data}, 8'h09);
    tick();
    chk("cont_r1_drop", {7'd0, bus0.rsp_valid}, 8'd0);
    chk("cont_cnt0", cnt0_0, 8'd1);
    chk("cont_g2_ready1", {7'd0, bus0.req1_ready}, 8'd1);
    chk("cont_g2_ready0", {7'd0, bus0.req0_ready}, 8'd0);
    tick();
    tick();
    tick();
    chk("cont_r2_valid", {7'd0, bus0.rsp_valid}, 8'd1);
    chk("cont_r2_id", {7'd0, bus0.rsp_id}, 8'd1);
    chk("cont_r2_data", {4'd0, bus0.rsp_data}, 8'h0F);
    tick();
    chk("cont_cnt1", cnt1_0, 8'd1);
    chk("fair_g3_ready0", {7'd0, bus0.req0_ready}, 8'd1);
    chk("fair_g3_ready1", {7'd0, bus0.req1_ready}, 8'd0);
    bus0.req0_valid = 1'b0;
    bus0.req1_valid = 1'b0;
    #1;
    chk("drop_ready0", {7'd0, bus0.req0_ready}, 8'd0);
    tick();
    chk("idle_busy", {7'd0, busy0}, 8'd0);
    chk("hold_alu_a", {6'd0, bus0.alu_a}, 8'd1);
    chk("hold_alu_b", {6'd0, bus0.alu_b}, 8'd2);
    chk("hold_alu_ctrl", {5'd0, bus0.alu_ctrl}, {5'd0, OP_SUB});

    // Single request, SUM 3+2.
    bus0.req0_op = OP_SUM; bus0.req0_a = 2'd3; bus0.req0_b = 2'd2; bus0.req0_valid = 1'b1;
    #1;
    chk("single_ready0", {7'd0, bus0.req0_ready}, 8'd1);
    tick();
    bus0.req0_valid = 1'b0;
    chk("single_c1_valid", {7'd0, bus0.rsp_valid}, 8'd0);
    tick();
    chk("single_c2_valid", {7'd0, bus0.rsp_valid}, 8'd0);
    tick();
    chk("single_c3_valid", {7'd0, bus0.rsp_valid}, 8'd1);
    chk("single_id", {7'd0, bus0.rsp_id}, 8'd0);
    chk("single_data", {4'd0, bus0.rsp_data}, 8'h05);
    tick();
    chk("single_drop", {7'd0, bus0.rsp_valid}, 8'd0);
    chk("single_cnt0", cnt0_0, 8'd2);

    // Backpressure: req1 MAX(2,1), response held while rsp_ready is low.
    bus0.rsp_ready = 1'b0;
    bus0.req1_op = OP_MAX; bus0.req1_a = 2'd2; bus0.req1_b = 2'd1; bus0.req1_valid = 1'b1;
    #1;
    chk("bp_ready1", {7'd0, bus0.req1_ready}, 8'd1);
    tick();
    bus0.req1_valid = 1'b0;
    bus0.req0_op = OP_OR; bus0.req0_a = 2'd1; bus0.req0_b = 2'd2; bus0.req0_valid = 1'b1;
    #1;
    chk("bp_issue_ready0", {7'd0, bus0.req0_ready}, 8'd0);
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {7'd0, bus0.rsp_valid}, 8'd1);
      chk("bp_data", {4'd0, bus0.rsp_data}, {4'd0, FLAG_A});
      chk("bp_id", {7'd0, bus0.rsp_id}, 8'd1);
      chk("bp_ready0", {7'd0, bus0.req0_ready}, 8'd0);
      chk("bp_cnt1", cnt1_0, 8'd1);
      tick();
    end
    bus0.rsp_ready = 1'b1;
    #1;
    chk("bp_cnt1_pre", cnt1_0, 8'd1);
    tick();
    chk("bp_drop", {7'd0, bus0.rsp_valid}, 8'd0);
    chk("bp_cnt1_post", cnt1_0, 8'd2);
    chk("bp_next_ready0", {7'd0, bus0.req0_ready}, 8'd1);
    tick();
    bus0.req0_valid = 1'b0;
    tick();
    tick();
    chk("bp_or_valid", {7'd0, bus0.rsp_valid}, 8'd1);
    chk("bp_or_id", {7'd0, bus0.rsp_id}, 8'd0);
    chk("bp_or_data", {4'd0, bus0.rsp_data}, 8'h03);
    tick();
    chk("bp_or_cnt0", cnt0_0, 8'd3);

    // Reset mid-ISSUE on the latency-3 instance.
    bus1.req0_op = OP_AND; bus1.req0_a = 2'd3; bus1.req0_b = 2'd1; bus1.req0_valid = 1'b1;
    #1;
    chk("mid_ready0", {7'd0, bus1.req0_ready}, 8'd1);
    tick();
    chk("mid_issue_busy", {7'd0, busy1}, 8'd1);
    chk("mid_issue_alu_a", {6'd0, bus1.alu_a}, 8'd3);
    rst1 = 1'b1;
    #1;
    chk("mid_busy", {7'd0, busy1}, 8'd0);
    chk("mid_alu_a", {6'd0, bus1.alu_a}, 8'd0);
    chk("mid_alu_b", {6'd0, bus1.alu_b}, 8'd0);
    chk("mid_alu_ctrl", {5'd0, bus1.alu_ctrl}, 8'd0);
    chk("mid_ready0_rst", {7'd0, bus1.req0_ready}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      chk("mid_no_rsp", {7'd0, bus1.rsp_valid}, 8'd0);
      chk("mid_cnt0", {6'd0, cnt0_1}, 8'd0);
      tick();
    end
    rst1 = 1'b0;

    // Re-grant after reset, then saturation and ALU_LATENCY=3 timing.
    op1(OP_AND, 2'd3, 2'd1, 4'h1, 2'd1);
    op1(OP_EQ, 2'd2, 2'd2, FLAG_E, 2'd2);
    op1(OP_EQ, 2'd2, 2'd2, FLAG_E, 2'd3);
    op1(OP_EQ, 2'd2, 2'd2, FLAG_E, 2'd3);
    op1(OP_EQ, 2'd2, 2'd2, FLAG_E, 2'd3);
    chk("sat_cnt1", {6'd0, cnt1_1}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered 2-bit ALU between two requesters (e.g. two teller stations).
- Uses round-robin arbitration with valid/ready handshakes.
- Latches the winning operation, drives the ALU operand/control inputs, waits out the ALU pipeline latency, captures the 4-bit result and returns it on a shared response channel tagged with the requester id.
- Keeps a saturating per-requester completion count for the status display.

Parameters:
ALU_LATENCY, 1, clock cycles from ALU inputs changing to the ALU result being valid (must be >= 1)
CNT_W, 8, width of each completion counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation pending
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  3  requester 0 ALU control code
req0_a  in  2  requester 0 operand A
req0_b  in  2  requester 0 operand B
req1_valid / req1_ready / req1_op / req1_a / req1_b  same as requester 0, for requester 1
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester the response belongs to
rsp_data  out  4  captured ALU result
alu_a  out  2  to ALU A
alu_b  out  2  to ALU B
alu_ctrl  out  3  to ALU Control
alu_result  in  4  from ALU Output
busy  out  1  high in any state other than IDLE
cnt0  out  CNT_W  completed responses for requester 0, saturating
cnt1  out  CNT_W  completed responses for requester 1, saturating

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, alu_a/alu_b/alu_ctrl=0, rsp_valid=0, rsp_id=0, rsp_data=0, cnt0=cnt1=0, busy=0.
- Both req*_ready outputs are 0 on reset and are 0 in every state other than IDLE.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE, arbitration:
  - Winner is the only valid requester, or rr_ptr if both are valid.
  - req<winner>_ready=1 is combinational in the same cycle. The handshake completes on that edge.
  - On the handshake, alu_a/alu_b/alu_ctrl are loaded from the winner's payload, the winner id is latched, rr_ptr is set to the other requester, and the FSM moves to ISSUE.
  - With no valid request, the FSM stays in IDLE and all registers hold.
- ISSUE: lasts exactly ALU_LATENCY cycles, timed by a latency counter, then moves to CAPTURE. alu_* outputs stay stable.
- CAPTURE: one cycle. rsp_data is loaded from alu_result at the end of the cycle, then the FSM moves to RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are held stable.
  - On rsp_valid&&rsp_ready, rsp_valid drops, cnt<id> increments (it saturates at all-ones and never wraps), and the FSM returns to IDLE.
- Latency: an operation accepted in cycle 0 has rsp_valid=1 in cycle ALU_LATENCY+2, i.e. cycle 3 at the default. The earliest next acceptance is one cycle after the response handshake.
- alu_* outputs hold their last issued values between operations and are not cleared on completion.
- Requester rules:
  - Payload must stay stable while valid&&!ready.
  - A requester that drops valid before ready is simply not granted.
  - The controller samples the payload only at the handshake.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Back-to-back: a requester re-asserting immediately after its own grant loses to the other requester if that one is valid.
- rsp_ready held low: the FSM stays in RESP indefinitely, and no new requests are accepted.
- Reset mid-operation in any state: everything returns to reset values immediately, the in-flight operation is discarded with no response and no count, and still-valid requesters are re-arbitrated from rr_ptr=0.
- No arithmetic is performed in this block. rsp_data is the ALU result passed through unchanged.

Decomposition:
- Shared package holds:
  - ALU control-code constants: OP_AND=000, OP_OR=001, OP_SUM=010, OP_SUB=011, OP_MUL=100, OP_MAX=101, OP_MIN=110, OP_EQ=111.
  - The FSM state encoding.
  - The result flag codes 4'hA, 4'hB, 4'hE.
- One natural sub-module: rr_arbiter2. It is combinational grant logic from the two valid bits and rr_ptr, producing a one-hot grant.
- The latency counter and completion counters stay inline.

Test Plan:
- Single request: req0 op=010 a=3 b=2, rsp_ready=1, ALU in loop. Required: req0_ready high in cycle 0, rsp_valid in cycle 3, rsp_id=0, rsp_data=4'h5, cnt0=1.
- Contention: both valid from reset, req0 op=100 a=3 b=3, req1 op=011 a=1 b=2. Required: first response id=0 data=4'h9, second id=1 data=4'hF, grant order 0 then 1.
- Backpressure: req1 op=101 a=2 b=1, rsp_ready=0 for 10 cycles. Required: rsp_valid stays 1, rsp_data=4'hA held, req0_ready stays 0 throughout, cnt1 increments only on the cycle rsp_ready goes high.
- Reset mid-ISSUE: assert reset during ISSUE for req0 op=000. Required: outputs go to reset values immediately, no rsp_valid, cnt0 unchanged, and after release req0 is re-granted and completes normally.
- Saturation: with CNT_W=2, complete 5 req0 operations. Required: cnt0 reads 1,2,3,3,3.
- Latency parameter: set ALU_LATENCY=3 and issue req0 op=111 a=2 b=2. Required: rsp_valid in cycle 5, rsp_data=4'hE.
